// File: rtl/read_req_arb_fifo_if.sv
// read_req_arb_fifo_if: requester-side, CXL AR/R-side and status signals of read_req_arb_fifo.
// master is the aggregator's view; slave is the environment's view.
interface read_req_arb_fifo_if #(
    parameter int CH = 4,
    parameter int DEPTH = 16,
    parameter int ADDR_W = 64,
    parameter int ID_W = 12,
    parameter int USER_W = 6,
    parameter int MAX_OUTST = 32
);
    logic [CH-1:0] arvalid_ch;
    logic [CH-1:0] arready_ch;
    logic [CH-1:0][ID_W-1:0] arid_ch;
    logic [CH-1:0][ADDR_W-1:0] araddr_ch;
    logic [CH-1:0][USER_W-1:0] aruser_ch;
    logic arvalid;
    logic arready;
    logic [ID_W-1:0] arid;
    logic [ADDR_W-1:0] araddr;
    logic [USER_W-1:0] aruser;
    logic rvalid;
    logic rlast;
    logic rready;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [$clog2(MAX_OUTST+1)-1:0] outst_count;
    logic rsp_underflow;
    logic [31:0] stat_accepted;
    logic [31:0] stat_full_cycles;

    modport master (
        input arvalid_ch, arid_ch, araddr_ch, aruser_ch, arready, rvalid, rlast,
        output arready_ch, arvalid, arid, araddr, aruser, rready,
        output fifo_count, outst_count, rsp_underflow, stat_accepted, stat_full_cycles
    );
    modport slave (
        output arvalid_ch, arid_ch, araddr_ch, aruser_ch, arready, rvalid, rlast,
        input arready_ch, arvalid, arid, araddr, aruser, rready,
        input fifo_count, outst_count, rsp_underflow, stat_accepted, stat_full_cycles
    );
endinterface

// File: rtl/read_req_arb_fifo.sv
// read_req_arb_fifo: round-robin AR aggregator feeding a FIFO, issue capped by outstanding reads.
// Define READ_REQ_ARB_FIFO_STATS_EN to enable the stat_accepted/stat_full_cycles counters.
module read_req_arb_fifo #(
    parameter int CH = 4,
    parameter int DEPTH = 16,
    parameter int ADDR_W = 64,
    parameter int ID_W = 12,
    parameter int USER_W = 6,
    parameter int MAX_OUTST = 32
) (
    input logic axi4_mm_clk,
    input logic axi4_mm_rst_n,
    read_req_arb_fifo_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = CH > 1 ? $clog2(CH) : 1;
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int EW = ID_W + USER_W + ADDR_W;

    logic [EW-1:0] mem [DEPTH];
    logic [PW:0] w_ptr, r_ptr;
    logic [CW-1:0] rr_ptr, gnt;
    logic [OW-1:0] outst;
    logic gnt_vld, full, empty, push, pop, rsp_done, underflow;

    assign empty = w_ptr == r_ptr;
    assign full = (w_ptr[PW-1:0] == r_ptr[PW-1:0]) && (w_ptr[PW] != r_ptr[PW]);

    // Descending scan so the channel nearest rr_ptr overwrites any later one.
    always_comb begin
        gnt_vld = 1'b0;
        gnt = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            logic [CW-1:0] c;
            c = CW'((int'(rr_ptr) + i) % CH);
            if (bus.arvalid_ch[c]) begin
                gnt_vld = 1'b1;
                gnt = c;
            end
        end
    end

    assign push = axi4_mm_rst_n && gnt_vld && !full;
    assign bus.arready_ch = push ? CH'(1) << gnt : '0;
    assign bus.arvalid = !empty && (outst < OW'(MAX_OUTST));
    assign pop = bus.arvalid && bus.arready;
    assign rsp_done = bus.rvalid && bus.rlast;
    assign {bus.arid, bus.aruser, bus.araddr} = mem[r_ptr[PW-1:0]];
    assign bus.rready = 1'b1;
    assign bus.fifo_count = w_ptr - r_ptr;
    assign bus.outst_count = outst;
    assign bus.rsp_underflow = underflow;

    always_ff @(posedge axi4_mm_clk)
        if (push) mem[w_ptr[PW-1:0]] <= {bus.arid_ch[gnt], bus.aruser_ch[gnt], bus.araddr_ch[gnt]};

    always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n)
        if (!axi4_mm_rst_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
            rr_ptr <= '0;
            outst <= '0;
            underflow <= 1'b0;
        end else begin
            if (push) begin
                w_ptr <= w_ptr + 1'b1;
                rr_ptr <= (gnt == CW'(CH - 1)) ? '0 : gnt + 1'b1;
            end
            if (pop) r_ptr <= r_ptr + 1'b1;
            if (pop && !rsp_done) outst <= outst + 1'b1;
            else if (rsp_done && !pop) begin
                outst <= (outst == '0) ? outst : outst - 1'b1;
                underflow <= underflow || (outst == '0);
            end
        end

`ifdef READ_REQ_ARB_FIFO_STATS_EN
    logic [31:0] stat_acc, stat_full;
    always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n)
        if (!axi4_mm_rst_n) begin
            stat_acc <= '0;
            stat_full <= '0;
        end else begin
            if (push) stat_acc <= stat_acc + 1'b1;
            if (full && |bus.arvalid_ch) stat_full <= stat_full + 1'b1;
        end
    assign bus.stat_accepted = stat_acc;
    assign bus.stat_full_cycles = stat_full;
`else
    assign bus.stat_accepted = '0;
    assign bus.stat_full_cycles = '0;
`endif
endmodule

// File: tb/tb_read_req_arb_fifo.sv
// tb_read_req_arb_fifo: directed and random stimulus checked against a queue-based reference model.
module tb_read_req_arb_fifo;
    localparam int CH = 4;
    localparam int DEPTH = 16;
    localparam int ADDR_W = 64;
    localparam int ID_W = 12;
    localparam int USER_W = 6;
    localparam int MAX_OUTST = 32;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [USER_W-1:0] user;
        logic [ADDR_W-1:0] addr;
    } ent_t;

    logic clk, rst_n;
    int total = 0, bad = 0;
    ent_t q[$];
    int rr = 0, outst = 0, last_g = -1, last_hs = 0;
    logic uf = 1'b0;
    longint stat_acc = 0, stat_full = 0;

    read_req_arb_fifo_if #(.CH(CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ID_W(ID_W),
                           .USER_W(USER_W), .MAX_OUTST(MAX_OUTST)) bus ();

    read_req_arb_fifo #(.CH(CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ID_W(ID_W),
                        .USER_W(USER_W), .MAX_OUTST(MAX_OUTST)) dut (
        .axi4_mm_clk(clk),
        .axi4_mm_rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_payload();
        for (int c = 0; c < CH; c++) begin
            bus.arid_ch[c] = ID_W'($urandom);
            bus.aruser_ch[c] = USER_W'($urandom);
            bus.araddr_ch[c] = {$urandom, $urandom};
        end
    endtask

    // One clock: drive at negedge, check against the model, then advance the model at posedge.
    task automatic step(input logic [CH-1:0] v, input logic rdy, input logic rl);
        int g;
        logic [CH-1:0] exp_rdy;
        logic exp_av;
        bus.arvalid_ch = v;
        bus.arready = rdy;
        bus.rvalid = rl;
        bus.rlast = rl;
        #1;
        g = -1;
        if (q.size() < DEPTH)
            for (int k = 0; k < CH; k++)
                if (g < 0 && v[(rr + k) % CH]) g = (rr + k) % CH;
        exp_rdy = (g >= 0) ? CH'(1) << g : '0;
        exp_av = (q.size() > 0) && (outst < MAX_OUTST);
        chk("arready_ch", bus.arready_ch, exp_rdy);
        chk("arvalid", bus.arvalid, exp_av);
        chk("rready", bus.rready, 1);
        if (exp_av) begin
            chk("arid", bus.arid, q[0].id);
            chk("aruser", bus.aruser, q[0].user);
            chk("araddr", bus.araddr, q[0].addr);
        end
        chk("fifo_count", bus.fifo_count, q.size());
        chk("outst_count", bus.outst_count, outst);
        chk("rsp_underflow", bus.rsp_underflow, uf);
`ifdef READ_REQ_ARB_FIFO_STATS_EN
        chk("stat_accepted", bus.stat_accepted, stat_acc[31:0]);
        chk("stat_full_cycles", bus.stat_full_cycles, stat_full[31:0]);
`else
        chk("stat_accepted", bus.stat_accepted, 0);
        chk("stat_full_cycles", bus.stat_full_cycles, 0);
`endif
        @(posedge clk);
        if (q.size() == DEPTH && v != 0) stat_full++;
        last_hs = (exp_av && rdy) ? 1 : 0;
        if (last_hs != 0) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back('{bus.arid_ch[g], bus.aruser_ch[g], bus.araddr_ch[g]});
            rr = (g + 1) % CH;
            stat_acc++;
        end
        if (last_hs != 0 && !rl) outst++;
        else if (rl && last_hs == 0) begin
            if (outst == 0) uf = 1'b1;
            else outst--;
        end
        last_g = g;
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle with requests pending; outputs must drop at once.
    task automatic do_reset();
        bus.arvalid_ch = '1;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rlast = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_arready_ch", bus.arready_ch, 0);
        chk("rst_fifo_count", bus.fifo_count, 0);
        chk("rst_outst_count", bus.outst_count, 0);
        chk("rst_underflow", bus.rsp_underflow, 0);
        q.delete();
        rr = 0;
        outst = 0;
        uf = 1'b0;
        stat_acc = 0;
        stat_full = 0;
        @(negedge clk);
        bus.arvalid_ch = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        int hs_sum;
        rst_n = 1'b0;
        bus.arvalid_ch = '0;
        bus.arready = 1'b0;
        bus.rvalid = 1'b0;
        bus.rlast = 1'b0;
        rand_payload();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset.
        repeat (20) step('0, 1'b0, 1'b0);

        // Round robin with fixed addresses, one grant and one issue per cycle.
        for (int c = 0; c < CH; c++) bus.araddr_ch[c] = 64'h1000 * c;
        for (int k = 0; k < 12; k++) begin
            step('1, 1'b1, 1'b0);
            chk("rr_grant", last_g, k % CH);
            chk("rr_head_addr", bus.araddr, 64'h1000 * (k % CH));
        end

        // Fill to full from channel 2, then drain.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            bus.araddr_ch[2] = {$urandom, $urandom};
            bus.arid_ch[2] = ID_W'(k);
            step(4'b0100, 1'b0, 1'b0);
        end
        chk("full_count", bus.fifo_count, DEPTH);
        chk("full_arready_ch", bus.arready_ch, 0);
        step(4'b0100, 1'b1, 1'b0);
        chk("full_first_pop_no_push", last_g, 64'hffff_ffff_ffff_ffff);
        chk("full_first_pop_hs", last_hs, 1);
        for (int k = 0; k < 22; k++) begin
            rand_payload();
            step((k < 4) ? 4'b0100 : 4'b0000, 1'b1, 1'b0);
        end
        chk("drain_empty", bus.fifo_count, 0);

        // Outstanding cap.
        do_reset();
        for (int k = 0; k < 45; k++) begin
            rand_payload();
            step('1, 1'b1, 1'b0);
        end
        chk("cap_arvalid", bus.arvalid, 0);
        chk("cap_outst", bus.outst_count, MAX_OUTST);
        chk("cap_fifo_nonempty", bus.fifo_count != 0, 1);
        hs_sum = 0;
        step('0, 1'b1, 1'b1);
        hs_sum += last_hs;
        repeat (3) begin
            step('0, 1'b1, 1'b0);
            hs_sum += last_hs;
        end
        chk("cap_one_issue", hs_sum, 1);
        chk("cap_outst_after", bus.outst_count, MAX_OUTST);

        // Simultaneous events at fifo_count=7, outst_count=5.
        do_reset();
        for (int k = 0; k < 12; k++) begin
            rand_payload();
            step(4'b0001, 1'b0, 1'b0);
        end
        repeat (5) step('0, 1'b1, 1'b0);
        chk("sim_pre_fifo", bus.fifo_count, 7);
        chk("sim_pre_outst", bus.outst_count, 5);
        step(4'b0010, 1'b1, 1'b1);
        chk("sim_fifo_7", bus.fifo_count, 7);
        chk("sim_outst_5", bus.outst_count, 5);

        // Underflow, then 40 push/pop pairs across the pointer wrap.
        do_reset();
        step('0, 1'b0, 1'b1);
        chk("uf_flag", bus.rsp_underflow, 1);
        chk("uf_outst", bus.outst_count, 0);
        for (int k = 0; k < 40; k++) begin
            rand_payload();
            step(CH'(1) << $urandom_range(CH - 1), 1'b1, 1'b1);
        end
        step('0, 1'b1, 1'b1);
        chk("wrap_empty", bus.fifo_count, 0);
        chk("uf_sticky", bus.rsp_underflow, 1);
`ifdef READ_REQ_ARB_FIFO_STATS_EN
        chk("wrap_stat_accepted", bus.stat_accepted, 40);
`else
        chk("wrap_stat_accepted", bus.stat_accepted, 0);
`endif

        // Random traffic.
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            rand_payload();
            step(CH'($urandom), ($urandom_range(9) < 7), ($urandom_range(9) < 3));
        end
        do_reset();
        step('0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
